// File: rtl/oram_writer_pkg.sv
// Shared definitions for oram_writer: FSM state encodings (OW_IDLE / OW_WRITE) and the state type.
// Build option ORAM_CHECKSUM_EN (see oram_writer.sv) enables the checksum accumulator.
`ifndef ORAM_CONSTS_VH
`define ORAM_CONSTS_VH
`define OW_IDLE  1'b0
`define OW_WRITE 1'b1
`endif

package oram_writer_pkg;

   typedef enum logic {
      ST_IDLE  = `OW_IDLE,
      ST_WRITE = `OW_WRITE
   } ow_state_e;

endpackage

// File: rtl/oram_writer_fifo.sv
// Synchronous show-ahead FIFO buffering translated words ahead of the byte serialiser.
// A push while full or a pop while empty is ignored.
module oram_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/oram_writer.sv
// Output-RAM writer: buffers translated words and serialises them one byte per cycle into RAM.
// Define ORAM_CHECKSUM_EN to accumulate an XOR checksum of completed words; otherwise checksum is 0.
module oram_writer
   import oram_writer_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int BYTE_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 8,
   parameter int BASE_ADDR  = 0,
   parameter int BIG_ENDIAN = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] data,
   output logic              in_ready,
   input  logic              finish,
   input  logic              oram_ready,
   output logic              oram_we,
   output logic [ADDR_W-1:0] oram_addr,
   output logic [BYTE_W-1:0] oram_wdata,
   output logic              done,
   output logic              overflow,
   output logic              ram_full,
   output logic [ADDR_W-1:0] word_count,
   output logic [DATA_W-1:0] checksum
);

   localparam int                BYTES     = DATA_W / BYTE_W;
   localparam int                IDX_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES - 1);

   ow_state_e         state_q;
   ow_state_e         state_d;
   logic [DATA_W-1:0] word_q;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  sel;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic              load;
   logic              byte_acc;
   logic              word_done;
   logic              hit_end;

   // Valid/ready: a word is taken when start && in_ready; start without in_ready loses the word.
   assign in_ready = !fifo_full;

   oram_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (start),
      .pop   (fifo_pop),
      .din   (data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d   = state_q;
      fifo_pop  = 1'b0;
      load      = 1'b0;
      byte_acc  = 1'b0;
      word_done = 1'b0;
      hit_end   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Once the RAM is full, queued words are popped and discarded.
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               if (!ram_full) begin
                  load    = 1'b1;
                  state_d = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            if (oram_ready) begin
               byte_acc  = 1'b1;
               hit_end   = (oram_addr == LAST_ADDR);
               word_done = (idx_q == LAST_IDX);
               if (hit_end) begin
                  state_d = ST_IDLE;
               end else if (word_done) begin
                  if (!fifo_empty) begin
                     fifo_pop = 1'b1;
                     load     = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign oram_we    = (state_q == ST_WRITE);
   assign sel        = (BIG_ENDIAN != 0) ? (LAST_IDX - idx_q) : idx_q;
   assign oram_wdata = word_q[32'(sel) * BYTE_W +: BYTE_W];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         word_q     <= '0;
         idx_q      <= '0;
         oram_addr  <= ADDR_W'(BASE_ADDR);
         word_count <= '0;
         done       <= 1'b0;
         overflow   <= 1'b0;
         ram_full   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            word_q <= fifo_dout;
            idx_q  <= '0;
         end else if (byte_acc) begin
            idx_q <= idx_q + 1'b1;
         end
         // The address parks on the last location instead of wrapping.
         if (byte_acc && !hit_end) begin
            oram_addr <= oram_addr + 1'b1;
         end
         if (byte_acc && hit_end) begin
            ram_full <= 1'b1;
         end
         if (word_done) begin
            word_count <= word_count + 1'b1;
         end
         if (start && fifo_full) begin
            overflow <= 1'b1;
         end
         if (finish && fifo_empty && (state_q == ST_IDLE)) begin
            done <= 1'b1;
         end
      end
   end

`ifdef ORAM_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         checksum_q <= '0;
      end else if (word_done) begin
         checksum_q <= checksum_q ^ word_q;
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_oram_writer.sv
// Bench for oram_writer: three instances (little-endian, big-endian, 4-bit address) share stimulus;
// a byte scoreboard per instance plus directed checks of latency, back-pressure, done and reset.
module tb_oram_writer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] data;
   logic        finish;
   logic        oram_ready;

   logic        le_in_ready, le_we, le_done, le_overflow, le_ram_full;
   logic [7:0]  le_addr, le_wdata, le_word_count;
   logic [31:0] le_checksum;
   logic        be_in_ready, be_we, be_done, be_overflow, be_ram_full;
   logic [7:0]  be_addr, be_wdata, be_word_count;
   logic [31:0] be_checksum;
   logic        sm_in_ready, sm_we, sm_done, sm_overflow, sm_ram_full;
   logic [3:0]  sm_addr, sm_word_count;
   logic [7:0]  sm_wdata;
   logic [31:0] sm_checksum;

   oram_writer u_le (
      .clk(clk), .reset(reset), .start(start), .data(data), .in_ready(le_in_ready),
      .finish(finish), .oram_ready(oram_ready), .oram_we(le_we), .oram_addr(le_addr),
      .oram_wdata(le_wdata), .done(le_done), .overflow(le_overflow), .ram_full(le_ram_full),
      .word_count(le_word_count), .checksum(le_checksum)
   );

   oram_writer #(.BIG_ENDIAN(1)) u_be (
      .clk(clk), .reset(reset), .start(start), .data(data), .in_ready(be_in_ready),
      .finish(finish), .oram_ready(oram_ready), .oram_we(be_we), .oram_addr(be_addr),
      .oram_wdata(be_wdata), .done(be_done), .overflow(be_overflow), .ram_full(be_ram_full),
      .word_count(be_word_count), .checksum(be_checksum)
   );

   oram_writer #(.ADDR_W(4)) u_sm (
      .clk(clk), .reset(reset), .start(start), .data(data), .in_ready(sm_in_ready),
      .finish(finish), .oram_ready(oram_ready), .oram_we(sm_we), .oram_addr(sm_addr),
      .oram_wdata(sm_wdata), .done(sm_done), .overflow(sm_overflow), .ram_full(sm_ram_full),
      .word_count(sm_word_count), .checksum(sm_checksum)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // Scoreboard: {addr, byte} in expected write order, one queue per instance.
   logic [15:0] exp_le[$];
   logic [15:0] exp_be[$];
   logic [15:0] exp_sm[$];
   int          ea;
   int          le_words, sm_words;
   logic [31:0] ck_le, ck_sm;

   typedef struct {
      logic [31:0] word;
      logic [31:0] le_seq;   // bytes in write order, first byte in [31:24]
      logic [31:0] be_seq;
   } vec_t;

   vec_t vecs[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ck_exp(input logic [31:0] x);
`ifdef ORAM_CHECKSUM_EN
      return x;
`else
      return 32'h0 & x;
`endif
   endfunction

   task automatic clear_model();
      exp_le.delete();
      exp_be.delete();
      exp_sm.delete();
      ea       = 0;
      le_words = 0;
      sm_words = 0;
      ck_le    = '0;
      ck_sm    = '0;
   endtask

   task automatic do_reset();
      reset      = 1'b0;
      start      = 1'b0;
      finish     = 1'b0;
      oram_ready = 1'b1;
      repeat (2) tick();
      reset = 1'b1;
      clear_model();
   endtask

   // ---------------- driver tasks ----------------
   task automatic expect_word(input logic [31:0] w, input logic [31:0] le_seq,
                              input logic [31:0] be_seq);
      for (int i = 0; i < 4; i++) begin
         exp_le.push_back({ea[7:0], le_seq[31-8*i -: 8]});
         exp_be.push_back({ea[7:0], be_seq[31-8*i -: 8]});
         if (ea < 16) exp_sm.push_back({4'h0, ea[3:0], le_seq[31-8*i -: 8]});
         ea++;
      end
      le_words++;
      ck_le ^= w;
      if (ea <= 16) begin
         sm_words++;
         ck_sm ^= w;
      end
   endtask

   task automatic expect_split(input logic [31:0] w);
      expect_word(w, {w[7:0], w[15:8], w[23:16], w[31:24]}, w);
   endtask

   task automatic push(input logic [31:0] w);
      start = 1'b1;
      data  = w;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_le.size() != 0 || exp_be.size() != 0 || exp_sm.size() != 0 ||
              le_we !== 1'b0 || be_we !== 1'b0 || sm_we !== 1'b0) && n < 400) begin
         tick();
         n++;
      end
      check("drain_in_time", 32'(n < 400), 32'd1);
      repeat (6) tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, le_in_ready, 1'b1);
      check({tag, "_we"}, le_we, 1'b0);
      check({tag, "_addr"}, le_addr, 8'h00);
      check({tag, "_wdata"}, le_wdata, 8'h00);
      check({tag, "_done"}, le_done, 1'b0);
      check({tag, "_overflow"}, le_overflow, 1'b0);
      check({tag, "_ram_full"}, le_ram_full, 1'b0);
      check({tag, "_word_count"}, le_word_count, 8'h00);
      check({tag, "_checksum"}, le_checksum, 32'h0);
      check({tag, "_sm_addr"}, sm_addr, 4'h0);
      check({tag, "_sm_ram_full"}, sm_ram_full, 1'b0);
   endtask

   // ---------------- monitors (sampled on the falling edge) ----------------
   always @(negedge clk) begin
      logic [15:0] e;
      if (reset === 1'b1 && oram_ready === 1'b1) begin
         if (le_we === 1'b1) begin
            n_vec++;
            if (exp_le.size() == 0) begin
               n_miss++;
               $display("FAIL le_byte: write addr=%0h data=%0h, required no write", le_addr, le_wdata);
            end else begin
               e = exp_le.pop_front();
               if ({le_addr, le_wdata} !== e) begin
                  n_miss++;
                  $display("FAIL le_byte: addr/data=%h, required %h", {le_addr, le_wdata}, e);
               end
            end
         end
         if (be_we === 1'b1) begin
            n_vec++;
            if (exp_be.size() == 0) begin
               n_miss++;
               $display("FAIL be_byte: write addr=%0h data=%0h, required no write", be_addr, be_wdata);
            end else begin
               e = exp_be.pop_front();
               if ({be_addr, be_wdata} !== e) begin
                  n_miss++;
                  $display("FAIL be_byte: addr/data=%h, required %h", {be_addr, be_wdata}, e);
               end
            end
         end
         if (sm_we === 1'b1) begin
            n_vec++;
            if (exp_sm.size() == 0) begin
               n_miss++;
               $display("FAIL sm_byte: write addr=%0h data=%0h, required no write", sm_addr, sm_wdata);
            end else begin
               e = exp_sm.pop_front();
               if ({4'h0, sm_addr, sm_wdata} !== e) begin
                  n_miss++;
                  $display("FAIL sm_byte: addr/data=%h, required %h", {4'h0, sm_addr, sm_wdata}, e);
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation still running, required finish");
      $fatal(1);
   end

   // ---------------- test sequence ----------------
   initial begin
      int n;
      logic [31:0] w0;

      vecs[0] = '{32'h11223344, 32'h44332211, 32'h11223344};
      vecs[1] = '{32'hE3A00001, 32'h0100A0E3, 32'hE3A00001};
      vecs[2] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
      vecs[3] = '{32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F};
      vecs[4] = '{32'hDEADBEEF, 32'hEFBEADDE, 32'hDEADBEEF};
      vecs[5] = '{32'h00000000, 32'h00000000, 32'h00000000};

      reset = 1'b0; start = 1'b0; data = '0; finish = 1'b0; oram_ready = 1'b1;
      clear_model();
      repeat (2) tick();
      check_reset_outputs("rst");
      reset = 1'b1;

      // Latency and byte order of a single word.
      expect_word(vecs[0].word, vecs[0].le_seq, vecs[0].be_seq);
      push(vecs[0].word);
      check("lat_we_early", le_we, 1'b0);
      tick();
      check("lat_we", le_we, 1'b1);
      check("lat_addr0", le_addr, 8'h00);
      check("lat_byte0_le", le_wdata, 8'h44);
      check("lat_byte0_be", be_wdata, 8'h11);
      repeat (3) tick();
      check("lat_addr3", le_addr, 8'h03);
      check("lat_byte3_le", le_wdata, 8'h11);
      tick();
      check("single_we_off", le_we, 1'b0);
      check("single_word_count", le_word_count, 8'd1);

      // Table vectors, one word every four cycles.
      for (int i = 0; i < 6; i++) begin
         expect_word(vecs[i].word, vecs[i].le_seq, vecs[i].be_seq);
         push(vecs[i].word);
         repeat (3) tick();
      end
      wait_drain();
      check("tbl_le_count", le_word_count, 32'(le_words));
      check("tbl_be_count", be_word_count, 32'(le_words));
      check("tbl_sm_count", sm_word_count, 32'(sm_words));
      check("tbl_le_addr", le_addr, ea[7:0]);
      check("tbl_sm_ram_full", sm_ram_full, 1'b1);
      check("tbl_sm_addr_parked", sm_addr, 4'hF);
      check("tbl_le_ram_full", le_ram_full, 1'b0);
      check("tbl_le_overflow", le_overflow, 1'b0);
      check("tbl_le_checksum", le_checksum, ck_exp(ck_le));
      check("tbl_sm_checksum", sm_checksum, ck_exp(ck_sm));

      // Back-pressure: one word sits in the writer, FIFO_DEPTH more fill the FIFO, the next is lost.
      do_reset();
      oram_ready = 1'b0;
      w0 = $urandom;
      for (int i = 0; i < 6; i++) begin
         data = (i == 0) ? w0 : $urandom;
         if (i < 5) expect_split(data);
         push(data);
         if (i == 3) check("bp_in_ready_open", le_in_ready, 1'b1);
         if (i == 4) begin
            check("bp_in_ready_full", le_in_ready, 1'b0);
            check("bp_no_overflow_yet", le_overflow, 1'b0);
         end
      end
      check("bp_overflow", le_overflow, 1'b1);
      check("bp_sm_overflow", sm_overflow, 1'b1);
      repeat (4) tick();
      check("bp_stall_we", le_we, 1'b1);
      check("bp_stall_addr", le_addr, 8'h00);
      check("bp_stall_byte", le_wdata, w0[7:0]);
      oram_ready = 1'b1;
      wait_drain();
      check("bp_le_count", le_word_count, 8'd5);
      check("bp_le_addr", le_addr, 8'd20);
      check("bp_sm_count", sm_word_count, 4'd4);
      check("bp_sm_ram_full", sm_ram_full, 1'b1);
      check("bp_sm_addr", sm_addr, 4'hF);
      check("bp_overflow_sticky", le_overflow, 1'b1);

      // Drain handshake and checksum of two words.
      do_reset();
      expect_word(32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
      push(32'hA5A5A5A5);
      expect_word(32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F);
      push(32'h0F0F0F0F);
      finish = 1'b1;
      n = 0;
      while (le_we === 1'b1 && n < 50) begin
         check("done_low_while_busy", le_done, 1'b0);
         tick();
         n++;
      end
      check("done_wait_bound", 32'(n < 50), 32'd1);
      check("done_not_yet", le_done, 1'b0);
      check("done_word_count", le_word_count, 8'd2);
      tick();
      check("done_rise", le_done, 1'b1);
      check("done_checksum", le_checksum, ck_exp(32'hAAAAAAAA));
      check("done_checksum_model", le_checksum, ck_exp(ck_le));
      expect_word(32'hDEADBEEF, 32'hEFBEADDE, 32'hDEADBEEF);
      push(32'hDEADBEEF);
      wait_drain();
      check("done_sticky", le_done, 1'b1);
      check("after_done_count", le_word_count, 8'd3);

      // Reset in the middle of a word.
      finish = 1'b0;
      expect_word(32'h12345678, 32'h78563412, 32'h12345678);
      push(32'h12345678);
      repeat (2) tick();
      check("mid_word_busy", le_we, 1'b1);
      reset = 1'b0;
      tick();
      check_reset_outputs("midrst");
      reset = 1'b1;
      clear_model();
      repeat (10) tick();
      check("midrst_no_resume", le_we, 1'b0);
      check("midrst_count", le_word_count, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
